imem_fetch_controller: RTL and testbench

Sequencer and arbiter for the single-port, byte-wide instruction memory. It shares the memory between the CPU fetch port and a program-loader write port. For each fetch it performs four consecutive byte reads and assembles a big-endian 32-bit instruction word. The block sits between the core's fetch stage, the boot/debug loader and the byte memory array.

---
 rtl/imem_fetch_controller.sv | 114 +++++++++++
 tb/tb_imem_fetch_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_controller.sv
// Instruction-memory sequencer: arbitrates loader byte writes against CPU fetches
// and assembles four consecutive byte reads into one big-endian 32-bit word.
module imem_fetch_controller #(
  parameter int unsigned MEM_ADDR_SIZE = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [MEM_ADDR_SIZE-1:0] fetch_addr,
  output logic                     fetch_ready,
  output logic                     fetch_valid,
  output logic [31:0]              fetch_data,
  input  logic                     load_valid,
  input  logic [MEM_ADDR_SIZE-1:0] load_addr,
  input  logic [7:0]               load_data,
  output logic                     load_ready,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic                     mem_we,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  output logic                     busy
);

  localparam int unsigned AW = MEM_ADDR_SIZE;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] base_q, base_d;
  // Only the low three bytes of the shift register ever feed the next word.
  logic [23:0]   shift_q, shift_d;
  logic [31:0]   fetch_data_q, fetch_data_d;
  logic          fetch_valid_q, fetch_valid_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 2'd0;
      base_q        <= '0;
      shift_q       <= 24'd0;
      fetch_data_q  <= 32'd0;
      fetch_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      shift_q       <= shift_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Next state, arbitration and memory port steering.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    shift_d       = shift_q;
    fetch_data_d  = fetch_data_q;
    fetch_valid_d = 1'b0;
    fetch_ready   = 1'b0;
    load_ready    = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wdata     = 8'd0;

    case (state_q)
      ST_IDLE: begin
        load_ready  = ~rst;
        fetch_ready = ~rst & ~load_valid;
        if (load_valid && load_ready) begin
          mem_we    = 1'b1;
          mem_addr  = load_addr;
          mem_wdata = load_data;
        end else if (fetch_req && fetch_ready) begin
          base_d  = fetch_addr;
          cnt_d   = 2'd0;
          shift_d = 24'd0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // Address wraps modulo memory depth by truncation.
        mem_addr = base_q + AW'(cnt_q);
        shift_d  = {shift_q[15:0], mem_rdata};
        cnt_d    = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          fetch_data_d  = {shift_q, mem_rdata};
          fetch_valid_d = 1'b1;
          state_d       = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller with a byte-memory model behind the
// memory port; expected words are hand-computed from the preset byte[i] = i image.
module tb_imem_fetch_controller;

  localparam int unsigned AW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          fetch_valid;
  logic [31:0]   fetch_data;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          load_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;

  logic [7:0] mem [64];
  logic       mem_init;
  int         wr_count;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  imem_fetch_controller #(.MEM_ADDR_SIZE(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_data (fetch_data),
    .load_valid (load_valid),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ready (load_ready),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .busy       (busy)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
      wr_count <= 0;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_count      <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues a fetch, waits (bounded) for acceptance, then checks the address
  // sequence, the cycle-5 valid pulse and the returned word.
  task automatic fetch_word(input logic [AW-1:0] a, input logic [31:0] exp,
                            input string tag, output int waited);
    logic [AW-1:0] ea;
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    waited = 0;
    while (!fetch_ready && waited < 20) begin
      step();
      waited++;
    end
    chk({tag, "_accept"}, 32'(fetch_ready), 32'd1);
    step();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    for (int c = 0; c < 4; c++) begin
      ea = a + AW'(c);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(ea));
      chk({tag, "_rd_no_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_no_valid"}, 32'(fetch_valid), 32'd0);
      step();
    end
    chk({tag, "_valid"}, 32'(fetch_valid), 32'd1);
    chk({tag, "_data"}, fetch_data, exp);
    chk({tag, "_done_fready"}, 32'(fetch_ready), 32'd0);
    step();
    chk({tag, "_valid_drop"}, 32'(fetch_valid), 32'd0);
    chk({tag, "_data_hold"}, fetch_data, exp);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  int w;
  int pulses;

  initial begin
    rst        = 1'b1;
    mem_init   = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = 8'd0;
    step();
    step();
    // Reset state and forced-low readies while reset is high.
    chk("rst_data", fetch_data, 32'h0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_fready", 32'(fetch_ready), 32'd0);
    chk("rst_lready", 32'(load_ready), 32'd0);
    mem_init = 1'b0;
    rst      = 1'b0;
    #1;
    chk("idle_lready", 32'(load_ready), 32'd1);
    chk("idle_fready", 32'(fetch_ready), 32'd1);
    step();

    // Basic fetch.
    fetch_word(6'h04, 32'h04050607, "f04", w);
    // Wrap past top of memory.
    fetch_word(6'h3E, 32'h3E3F0001, "wrap", w);

    // Contention: write wins, fetch goes next cycle and sees the new byte.
    load_valid = 1'b1;
    load_addr  = 6'h10;
    load_data  = 8'hAA;
    fetch_req  = 1'b1;
    fetch_addr = 6'h10;
    #1;
    chk("cont_lready", 32'(load_ready), 32'd1);
    chk("cont_fready", 32'(fetch_ready), 32'd0);
    chk("cont_we", 32'(mem_we), 32'd1);
    chk("cont_addr", 32'(mem_addr), 32'h10);
    chk("cont_wdata", 32'(mem_wdata), 32'hAA);
    step();
    load_valid = 1'b0;
    fetch_word(6'h10, 32'hAA111213, "cont", w);
    chk("cont_wait", 32'(w), 32'd0);

    // Hold-off: loader arrives in cycle 2 of a fetch.
    fetch_req  = 1'b1;
    fetch_addr = 6'h20;
    #1;
    chk("hold_accept", 32'(fetch_ready), 32'd1);
    step();
    fetch_req  = 1'b0;
    step();
    load_valid = 1'b1;
    load_addr  = 6'h21;
    load_data  = 8'h55;
    for (int c = 2; c <= 4; c++) begin
      #1;
      chk("hold_lready", 32'(load_ready), 32'd0);
      chk("hold_we", 32'(mem_we), 32'd0);
      step();
    end
    chk("hold_valid", 32'(fetch_valid), 32'd1);
    chk("hold_data", fetch_data, 32'h20212223);
    chk("hold_done_we", 32'(mem_we), 32'd0);
    step();
    chk("hold_grant", 32'(load_ready), 32'd1);
    chk("hold_grant_we", 32'(mem_we), 32'd1);
    chk("hold_grant_addr", 32'(mem_addr), 32'h21);
    step();
    load_valid = 1'b0;
    #1;
    chk("hold_wr_count", 32'(wr_count), 32'd2);
    chk("hold_mem", 32'(mem[6'h21]), 32'h55);
    fetch_word(6'h20, 32'h20552223, "hold_rd", w);

    // Reset in cycle 3 of a fetch abandons it.
    fetch_req  = 1'b1;
    fetch_addr = 6'h08;
    #1;
    chk("rmid_accept", 32'(fetch_ready), 32'd1);
    step();
    fetch_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_data", fetch_data, 32'h0);
    chk("rmid_addr", 32'(mem_addr), 32'h0);
    chk("rmid_fready", 32'(fetch_ready), 32'd0);
    step();
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      if (fetch_valid) pulses++;
      step();
    end
    chk("rmid_no_valid", 32'(pulses), 32'd0);
    chk("rmid_busy_after", 32'(busy), 32'd0);

    // Back-to-back fetches: valid at cycles 5 and 11.
    fetch_word(6'h00, 32'h00010203, "b2b0", w);
    fetch_word(6'h08, 32'h08090A0B, "b2b1", w);
    chk("b2b_wait", 32'(w), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
